// File: rtl/input_buffer_ctrl.sv
// Sequencer for the CNN-mode input buffer: one parallel load, then K taps with serial shifts between them.
// Optional stall counter is built when INPUT_BUFFER_CTRL_STALL_CNT_EN is defined.
module input_buffer_ctrl #(
   parameter int N_DIM_ARRAY = 4,
   parameter int SHIFT_BITS  = 8,
   parameter int K_BITS      = 4,
   parameter int WIN_BITS    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [2:0]            mode,
   input  logic [K_BITS-1:0]     cfg_k,
   input  logic [SHIFT_BITS-1:0] cfg_shift,
   input  logic [WIN_BITS-1:0]   cfg_n_win,
   output logic                  mem_req,
   input  logic                  mem_ack,
   output logic                  ser_req,
   input  logic                  ser_valid,
   output logic                  clear,
   output logic                  loading_in_parallel,
   output logic                  enable,
   output logic [SHIFT_BITS-1:0] shift_input_buffer,
   output logic                  pe_valid,
   input  logic                  pe_ready,
   output logic [K_BITS-1:0]     tap_idx,
   output logic [WIN_BITS-1:0]   win_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err,
   output logic [15:0]           stall_cycles,
   output logic [2:0]            state_dbg
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CLR       = 3'd1,
      LREQ      = 3'd2,
      LSET      = 3'd3,
      TAP       = 3'd4,
      SREQ      = 3'd5,
      CLR_ABORT = 3'd6
   } state_t;

   localparam logic [2:0]            MODE_CNN  = 3'd1;
   localparam logic [SHIFT_BITS-1:0] MAX_SHIFT = SHIFT_BITS'(N_DIM_ARRAY);

   state_t                state;
   logic [K_BITS-1:0]     k_q;
   logic [SHIFT_BITS-1:0] shift_q;
   logic [WIN_BITS-1:0]   n_win_q;

   logic                  cfg_bad;
   logic                  start_ok;
   logic                  last_tap;
   logic                  last_win;
   logic [K_BITS-1:0]     tap_next;
   logic [WIN_BITS-1:0]   win_next;

   assign cfg_bad  = (mode != MODE_CNN) || (cfg_k == '0) || (cfg_shift == '0) ||
                     (cfg_shift > MAX_SHIFT);
   assign start_ok = (state == IDLE) && start && !cfg_bad;
   assign last_tap = (tap_idx == (k_q - K_BITS'(1)));
   assign last_win = (({1'b0, win_idx} + (WIN_BITS+1)'(1)) == {1'b0, n_win_q});
   assign tap_next = (tap_idx == '1) ? tap_idx : tap_idx + K_BITS'(1);
   assign win_next = (win_idx == '1) ? win_idx : win_idx + WIN_BITS'(1);

   // Handshakes: a request (mem_req, ser_req, pe_valid) stays high until the
   // partner's ack/valid/ready is seen high at a rising edge; that edge completes
   // the transfer. Abort in the same cycle wins and cancels the transfer.
   assign mem_req             = (state == LREQ);
   assign ser_req             = (state == SREQ);
   assign pe_valid            = (state == TAP);
   assign busy                = (state != IDLE);
   assign loading_in_parallel = (state == LREQ) && mem_ack && !abort;
   assign enable              = (state == SREQ) && ser_valid && !abort;
   assign shift_input_buffer  = busy ? shift_q : '0;
   assign state_dbg           = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         k_q     <= '0;
         shift_q <= '0;
         n_win_q <= '0;
         tap_idx <= '0;
         win_idx <= '0;
         clear   <= 1'b0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         clear   <= 1'b0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         if (abort && state != IDLE) begin
            state <= CLR_ABORT;
            clear <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (cfg_bad) begin
                        cfg_err <= 1'b1;
                     end else begin
                        k_q     <= cfg_k;
                        shift_q <= cfg_shift;
                        n_win_q <= cfg_n_win;
                        clear   <= 1'b1;
                        // An empty job completes on the spot without touching memory.
                        if (cfg_n_win == '0) done  <= 1'b1;
                        else                 state <= CLR;
                     end
                  end
               end
               CLR: begin
                  tap_idx <= '0;
                  win_idx <= '0;
                  state   <= LREQ;
               end
               LREQ: if (mem_ack) state <= LSET;
               LSET: state <= TAP;
               TAP: begin
                  if (pe_ready) begin
                     if (!last_tap) begin
                        state <= SREQ;
                     end else begin
                        tap_idx <= '0;
                        win_idx <= win_next;
                        if (last_win) begin
                           done  <= 1'b1;
                           state <= IDLE;
                        end else begin
                           state <= LREQ;
                        end
                     end
                  end
               end
               SREQ: begin
                  if (ser_valid) begin
                     tap_idx <= tap_next;
                     state   <= TAP;
                  end
               end
               CLR_ABORT: state <= IDLE;
               default:   state <= IDLE;
            endcase
         end
      end
   end

`ifdef INPUT_BUFFER_CTRL_STALL_CNT_EN
   logic stall_now;

   assign stall_now = busy && ((mem_req && !mem_ack) || (ser_req && !ser_valid) ||
                               (pe_valid && !pe_ready));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                  stall_cycles <= '0;
      else if (start_ok)                           stall_cycles <= '0;
      else if (stall_now && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
   end
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Directed bench for input_buffer_ctrl: nominal job, backpressure, config errors,
// abort, K=1, empty job and asynchronous reset, each with hand-computed expectations.
module tb_input_buffer_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic        abort;
   logic [2:0]  mode;
   logic [3:0]  cfg_k;
   logic [7:0]  cfg_shift;
   logic [7:0]  cfg_n_win;
   logic        mem_req;
   logic        mem_ack;
   logic        ser_req;
   logic        ser_valid;
   logic        clear;
   logic        loading_in_parallel;
   logic        enable;
   logic [7:0]  shift_input_buffer;
   logic        pe_valid;
   logic        pe_ready;
   logic [3:0]  tap_idx;
   logic [7:0]  win_idx;
   logic        busy;
   logic        done;
   logic        cfg_err;
   logic [15:0] stall_cycles;
   logic [2:0]  state_dbg;

   int vectors;
   int miscompares;

`ifdef INPUT_BUFFER_CTRL_STALL_CNT_EN
   localparam bit STALL_ON = 1'b1;
`else
   localparam bit STALL_ON = 1'b0;
`endif

   // {clear, load, enable, pe_valid, mem_req, ser_req, busy, done} for cycles 1..17
   // of a K=3, n_win=2 job with every partner always ready.
   logic [7:0] nom_v [1:17] = '{8'h82, 8'h4A, 8'h02, 8'h12, 8'h26, 8'h12, 8'h26, 8'h12,
                                8'h4A, 8'h02, 8'h12, 8'h26, 8'h12, 8'h26, 8'h12, 8'h01,
                                8'h00};

   input_buffer_ctrl dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .abort               (abort),
      .mode                (mode),
      .cfg_k               (cfg_k),
      .cfg_shift           (cfg_shift),
      .cfg_n_win           (cfg_n_win),
      .mem_req             (mem_req),
      .mem_ack             (mem_ack),
      .ser_req             (ser_req),
      .ser_valid           (ser_valid),
      .clear               (clear),
      .loading_in_parallel (loading_in_parallel),
      .enable              (enable),
      .shift_input_buffer  (shift_input_buffer),
      .pe_valid            (pe_valid),
      .pe_ready            (pe_ready),
      .tap_idx             (tap_idx),
      .win_idx             (win_idx),
      .busy                (busy),
      .done                (done),
      .cfg_err             (cfg_err),
      .stall_cycles        (stall_cycles),
      .state_dbg           (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] vec();
      return {clear, loading_in_parallel, enable, pe_valid, mem_req, ser_req, busy, done};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [2:0] m, input logic [3:0] k, input logic [7:0] s,
                          input logic [7:0] nw);
      mode      = m;
      cfg_k     = k;
      cfg_shift = s;
      cfg_n_win = nw;
   endtask

   // Runs from the current cycle until done or the budget expires; done_cyc is -1 on timeout.
   task automatic run_job(input int first_cyc, input int budget, input logic [7:0] exp_shift,
                          output int done_cyc, output int n_en, output int n_ld,
                          output int n_beat, output int n_bad);
      int cyc;
      cyc = first_cyc;
      done_cyc = -1;
      n_en = 0;
      n_ld = 0;
      n_beat = 0;
      n_bad = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         start = 1'b0;
         cyc++;
         if (enable) n_en++;
         if (loading_in_parallel) n_ld++;
         if (pe_valid && pe_ready) n_beat++;
         if ((int'(clear) + int'(loading_in_parallel) + int'(enable)) > 1) n_bad++;
         if (pe_valid && (enable || loading_in_parallel)) n_bad++;
         if (shift_input_buffer !== (busy ? exp_shift : 8'd0)) n_bad++;
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
   endtask

   task automatic run_nominal(input string tag);
      int beat;
      beat = 0;
      set_cfg(3'd1, 4'd3, 8'd1, 8'd2);
      mem_ack = 1'b1; ser_valid = 1'b1; pe_ready = 1'b1; abort = 1'b0;
      start = 1'b1;
      #1;
      chk({tag, "_c0"}, 32'(vec()), 32'h00);
      for (int c = 1; c <= 17; c++) begin
         tick();
         start = 1'b0;
         chk($sformatf("%s_c%0d", tag, c), 32'(vec()), 32'(nom_v[c]));
         chk($sformatf("%s_shift_c%0d", tag, c), 32'(shift_input_buffer),
             nom_v[c][1] ? 32'd1 : 32'd0);
         if (nom_v[c][4]) begin
            chk($sformatf("%s_tap_b%0d", tag, beat), 32'(tap_idx), 32'(beat % 3));
            chk($sformatf("%s_win_b%0d", tag, beat), 32'(win_idx), 32'(beat / 3));
            beat++;
         end
      end
      chk({tag, "_stall"}, 32'(stall_cycles), 32'd0);
   endtask

   initial begin
      int dcyc, n_en, n_ld, n_beat, n_bad;
      vectors = 0;
      miscompares = 0;
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      set_cfg(3'd0, 4'd0, 8'd0, 8'd0);
      mem_ack = 1'b0; ser_valid = 1'b0; pe_ready = 1'b0;

      // reset state
      repeat (2) tick();
      chk("rst_vec", 32'(vec()), 32'h00);
      chk("rst_cfg_err", 32'(cfg_err), 32'd0);
      chk("rst_shift", 32'(shift_input_buffer), 32'd0);
      chk("rst_tap", 32'(tap_idx), 32'd0);
      chk("rst_win", 32'(win_idx), 32'd0);
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);
      reset = 1'b1;
      tick();

      // nominal job
      run_nominal("nom");

      // backpressure: pe_ready low for 5 cycles at tap 1
      set_cfg(3'd1, 4'd3, 8'd1, 8'd2);
      start = 1'b1;
      repeat (6) begin
         tick();
         start = 1'b0;
      end
      chk("bp_c6_vec", 32'(vec()), 32'h12);
      chk("bp_c6_tap", 32'(tap_idx), 32'd1);
      pe_ready = 1'b0;
      for (int c = 6; c <= 10; c++) begin
         if (c > 6) tick();
         chk($sformatf("bp_hold_vec_c%0d", c), 32'(vec()), 32'h12);
         chk($sformatf("bp_hold_tap_c%0d", c), 32'(tap_idx), 32'd1);
      end
      tick();
      pe_ready = 1'b1;
      #1;
      chk("bp_c11_vec", 32'(vec()), 32'h12);
      chk("bp_c11_tap", 32'(tap_idx), 32'd1);
      chk("bp_stall", 32'(stall_cycles), STALL_ON ? 32'd5 : 32'd0);
      run_job(11, 40, 8'd1, dcyc, n_en, n_ld, n_beat, n_bad);
      chk("bp_done_cyc", 32'(dcyc), 32'd21);
      chk("bp_enables", 32'(n_en), 32'd3);
      chk("bp_bad", 32'(n_bad), 32'd0);
      chk("bp_stall_end", 32'(stall_cycles), STALL_ON ? 32'd5 : 32'd0);
      tick();

      // rejected starts
      for (int i = 0; i < 4; i++) begin
         set_cfg((i == 0) ? 3'd0 : 3'd1, (i == 1) ? 4'd0 : 4'd3,
                 (i == 2) ? 8'd0 : ((i == 3) ? 8'd5 : 8'd1), 8'd2);
         start = 1'b1;
         tick();
         start = 1'b0;
         chk($sformatf("cerr%0d_pulse", i), 32'(cfg_err), 32'd1);
         chk($sformatf("cerr%0d_vec", i), 32'(vec()), 32'h00);
         tick();
         chk($sformatf("cerr%0d_after", i), 32'(cfg_err), 32'd0);
         chk($sformatf("cerr%0d_vec2", i), 32'(vec()), 32'h00);
      end
      chk("cerr_stall_kept", 32'(stall_cycles), STALL_ON ? 32'd5 : 32'd0);

      // abort during SREQ with ser_valid in the same cycle
      set_cfg(3'd1, 4'd3, 8'd1, 8'd2);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ab_stall_cleared", 32'(stall_cycles), 32'd0);
      repeat (4) tick();
      abort = 1'b1;
      #1;
      chk("ab_sreq_vec", 32'(vec()), 32'h06);
      tick();
      abort = 1'b0;
      #1;
      chk("ab_clr_vec", 32'(vec()), 32'h82);
      tick();
      chk("ab_idle_vec", 32'(vec()), 32'h00);
      tick();
      run_nominal("renom");

      // K=1, three windows, maximum shift
      set_cfg(3'd1, 4'd1, 8'd4, 8'd3);
      start = 1'b1;
      run_job(0, 40, 8'd4, dcyc, n_en, n_ld, n_beat, n_bad);
      chk("k1_done_cyc", 32'(dcyc), 32'd11);
      chk("k1_loads", 32'(n_ld), 32'd3);
      chk("k1_beats", 32'(n_beat), 32'd3);
      chk("k1_enables", 32'(n_en), 32'd0);
      chk("k1_bad", 32'(n_bad), 32'd0);
      tick();

      // empty job
      set_cfg(3'd1, 4'd3, 8'd1, 8'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("nw0_vec", 32'(vec()), 32'h81);
      tick();
      chk("nw0_after", 32'(vec()), 32'h00);

      // asynchronous reset in TAP at tap 1
      set_cfg(3'd1, 4'd3, 8'd1, 8'd2);
      start = 1'b1;
      repeat (6) begin
         tick();
         start = 1'b0;
      end
      chk("ar_tap_vec", 32'(vec()), 32'h12);
      chk("ar_tap_idx", 32'(tap_idx), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_vec", 32'(vec()), 32'h00);
      chk("ar_tap", 32'(tap_idx), 32'd0);
      chk("ar_shift", 32'(shift_input_buffer), 32'd0);
      chk("ar_stall", 32'(stall_cycles), 32'd0);
      chk("ar_state", 32'(state_dbg), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      chk("ar_post_vec", 32'(vec()), 32'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/input_buffer_ctrl.md
Name: input_buffer_ctrl

Overview:
- Sequencer for the CNN-mode input buffer, which holds N_DIM_ARRAY 8-bit activations and is fed by a parallel load followed by serial shifts.
- Per job it runs a number of windows. Each window is one parallel load followed by K taps, with a serial shift of cfg_shift elements between consecutive taps.
- Sits between the activation memory / serial feeder and the input buffer. Drives the buffer's clear, loading_in_parallel, enable and shift_input_buffer, and gates the valid of the buffer output toward the PE array.

Parameters:
- N_DIM_ARRAY, 4, buffer depth in elements.
- SHIFT_BITS, 8, width of shift_input_buffer.
- K_BITS, 4, width of kernel-size field.
- WIN_BITS, 8, width of window-count field.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job start; sampled in IDLE only.
- abort  in  1  synchronous abort, any state.
- mode  in  3  layer mode; CNN=1, FC=0, EWS=3.
- cfg_k  in  K_BITS  kernel taps K; latched on start.
- cfg_shift  in  SHIFT_BITS  elements shifted per tap; latched on start.
- cfg_n_win  in  WIN_BITS  windows per job; latched on start.
- mem_req  out  1  parallel-load request.
- mem_ack  in  1  parallel data valid; memory holds it for 1 further cycle.
- ser_req  out  1  serial-data request.
- ser_valid  in  1  serial data valid this cycle.
- clear  out  1  buffer clear.
- loading_in_parallel  out  1  buffer parallel load (buffer registers it internally).
- enable  out  1  buffer serial shift.
- shift_input_buffer  out  SHIFT_BITS  shift amount.
- pe_valid  out  1  buffer output holds a valid tap.
- pe_ready  in  1  PE array accepts the tap.
- tap_idx  out  K_BITS  current tap.
- win_idx  out  WIN_BITS  current window.
- busy  out  1  not IDLE.
- done  out  1  one-cycle job completion pulse.
- cfg_err  out  1  one-cycle pulse on a rejected start.
- stall_cycles  out  16  optional counter (see Optional Feature).

Behaviour:
- Reset: all outputs 0; state IDLE; latched cfg 0.
- shift_input_buffer = latched cfg_shift when busy, else 0.
- States and transitions:
  - IDLE: on start go to CLR.
    - Start is rejected if mode!=1, cfg_k==0, cfg_shift==0 or cfg_shift>N_DIM_ARRAY. A rejected start pulses cfg_err and stays in IDLE; clear is not pulsed.
    - cfg_n_win==0: pulse clear and done in the same cycle, then return to IDLE.
  - CLR: clear=1 for 1 cycle; tap=0, win=0; go to LREQ.
  - LREQ: mem_req=1 until mem_ack.
    - In the mem_ack cycle, loading_in_parallel=1 for 1 cycle; go to LSET.
  - LSET: 1 idle cycle while the buffer captures the data; go to TAP.
  - TAP: pe_valid=1, held until pe_ready.
    - On pe_ready with tap<K-1: go to SREQ.
    - On pe_ready with tap==K-1: tap=0 and win++. If win+1==n_win, pulse done and go to IDLE; else go to LREQ.
  - SREQ: ser_req=1 until ser_valid.
    - In the ser_valid cycle, enable=1 for 1 cycle and tap++; go to TAP.
    - TAP is entered on the next cycle, after the buffer has updated.
- Latency, with zero memory/feeder wait: start→first pe_valid = 4 cycles (CLR, LREQ+ack, LSET, TAP).
  - Each additional tap costs 2 cycles if pe_ready and ser_valid are held high.
- Mutual exclusion: loading_in_parallel, enable and clear are never asserted in the same cycle.
  - pe_valid is never asserted in the same cycle as enable or loading_in_parallel.
- Abort, in any busy state: next state CLR_ABORT.
  - CLR_ABORT: clear=1 for 1 cycle, then IDLE; no done.
  - An abort in IDLE is ignored.
  - Abort has priority over ack/valid/ready arriving in the same cycle; no enable or load is issued in that cycle.
- start while busy: ignored.
- K==1: no SREQ is ever entered; each window is load→TAP→next window.
- Counters: win and tap saturate at their field widths. The configuration ranges above keep them from wrapping.
- Reset mid-job: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro: INPUT_BUFFER_CTRL_STALL_CNT_EN.
- Defined: stall_cycles counts cycles with busy=1 and any of:
  - mem_req && !mem_ack;
  - ser_req && !ser_valid;
  - pe_valid && !pe_ready.
  
  It saturates at 0xFFFF and clears on accepted start and on reset.
- Undefined: stall_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- Setup for scenarios 1–2: mode=1, K=3, shift=1, n_win=2, with mem_ack, ser_valid and pe_ready all held 1.
- Nominal job: clear at cycle 1, load at cycle 2, pe_valid at cycles 4, 6, 8 with tap_idx 0, 1, 2; second window follows; done after 6 accepted taps; total enable pulses=4, each with shift_input_buffer=1.
- Backpressure: same config with pe_ready low for 5 cycles at tap 1 → pe_valid and tap_idx stay stable, no enable; stall_cycles=5 when the macro is defined.
- Config errors: start with mode=0, with K=0, with shift=0 and with shift=5 → cfg_err pulse each time, busy stays 0, no clear.
- Abort: abort during SREQ with ser_valid=1 in the same cycle → no enable, clear pulse in the next cycle, then IDLE with no done. A new start then runs a nominal job.
- Edge cases:
  - K=1, n_win=3, shift=4 → 3 loads, 3 pe_valid beats, zero enables.
  - n_win=0 → clear and done in the same cycle, no mem_req.
  - Async reset asserted mid-TAP → all outputs 0 immediately.
